ldst_control_unit: RTL and testbench
====================================

// Module: ldst_control_unit
// PURPOSE
//  Hardwired Moore control sequencer that drives the DataPath strobes for instruction fetch plus ld/ldi/st.
//  Sits directly upstream of DataPath and replaces the hand-driven control sequence now used by the benches.
//  Decodes IR[31:27], steps T0..T7 per instruction, stretches memory accesses by MEM_WAIT cycles, halts on halt/stop.
// PARAMETERS
//  MEM_WAIT  0         extra cycles Read/MDRin (or we) are held per memory access, 0..15
//  OP_LD     5'b00000  ld opcode;  OP_LDI 5'b00001 ldi;  OP_ST 5'b00010 st
//  OP_NOP    5'b11010  nop opcode; OP_HALT 5'b11011 halt
//  ALU_ADD   5'b00011  alu_op code for effective-address add
// PORTS
//  clock     in   1   system clock, rising edge
//  clear     in   1   asynchronous, active-high reset
//  ir        in   32  instruction register contents (opcode = ir[31:27])
//  stop      in   1   request halt at next instruction boundary
//  PCout,IncPC,PCin,MARin,Read,MDRin,MDRout,IRin  out 1 each  fetch/memory strobes
//  Gra,Grb,Rin,Rout,BAout,Yin,Cout,ZlowIn,Zlowout out 1 each  select/encode and ALU strobes
//  we        out  1   memory write enable
//  alu_op    out  5   ALU operation select (ALU_ADD in T4 of ld/ldi/st, else 5'b0)
//  run       out  1   1 while sequencing, 0 in HALT
//  illegal   out  1   sticky unknown-opcode flag (only with CTRL_ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  - Reset: state<=RESET, wait counter<=0, illegal<=0; all strobes 0, alu_op=0, run=0. clear mid-instruction aborts at once.
//  - RESET -> T0 unconditionally next edge. Outputs are pure decode of state (+counter); no Mealy paths.
//  - Fetch: T0 PCout,MARin,IncPC,ZlowIn | T1 Zlowout,PCin,Read,MDRin | T2 MDRout,IRin.
//  - T2 decodes ir[31:27] on the edge leaving T2; ir must be stable in T2.
//  - ld : T3 Grb,BAout,Yin,Rout | T4 Cout,ZlowIn,alu_op=ADD | T5 Zlowout,MARin | T6 Read,MDRin | T7 MDRout,Gra,Rin.
//  - ldi: T3..T4 as ld | T5 Zlowout,Gra,Rin -> done.
//  - st : T3..T5 as ld | T6 Gra,Rout,MDRin (Read=0 selects bus) | T7 we -> done.
//  - nop: done after T2. halt: T2 -> HALT; HALT holds (run=0, all strobes 0) until clear.
//  - Memory wait: in states asserting Read or we (T1, ld T6, st T7) the state holds MEM_WAIT extra cycles,
//    strobes steady; counter counts 0..MEM_WAIT, resets to 0 on leaving. MEM_WAIT=0 -> one cycle, no stall.
//  - "done" = go to T0, or to HALT if stop=1 sampled on that same edge. stop ignored mid-instruction.
//  - Rout is never asserted in the same state as Rin; we never overlaps Read.
// CONFIGURATION
//  - CTRL_ILLEGAL_TRAP_EN defined: unknown opcode at T2 -> HALT, illegal set to 1 (sticky until clear).
//  - Not defined: unknown opcode treated as nop (T2 -> T0); illegal tied 0.
// STRUCTURE
//  - Shared package cpu_ctrl_pkg: 4-bit state encoding (RESET,T0..T7,HALT), opcode constants, ALU_ADD.
//  - State T3..T7 shared across ld/ldi/st; a 2-bit instruction-class register selects per-class decode.
//  - One sub-module: mem_wait_counter (4-bit, load/clear/done) used for all memory stalls.
// TESTING
//  - Fetch+st, MEM_WAIT=0, ir=32'h1180_0000 (st) -> T0..T7 in 8 cycles after RESET; we=1 exactly in T7; back to T0.
//  - ld, MEM_WAIT=2 -> Read=MDRin=1 for 3 cycles in T1 and ld T6; 12 total cycles per ld; Rin=1 in T7 only.
//  - ldi -> alu_op=5'b00011 only in T4; Gra,Rin,Zlowout together in T5; next cycle T0.
//  - halt opcode 5'b11011 -> HALT after T2, run=0, outputs 0 for 20 cycles; clear -> RESET -> T0.
//  - stop=1 pulsed during ld T4 -> instruction completes, then HALT; stop during T7 edge -> HALT.
//  - ir opcode 5'b10111: with CTRL_ILLEGAL_TRAP_EN -> HALT, illegal=1; without -> T0, illegal=0. clear asserted in T5 -> all strobes 0 asynchronously.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding, instruction classes and opcode constants for the ld/ldi/st control sequencer
package cpu_ctrl_pkg;
   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;
   // Class latched when leaving T2; selects the per-class decode of T5..T7
   typedef enum logic [1:0] {CLS_LD, CLS_LDI, CLS_ST, CLS_NONE} cls_t;
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;
   localparam logic [4:0] ALU_ADD = 5'b00011;
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: 4-bit stall counter holding a memory state for LIMIT extra cycles
//  clock in  rising-edge clock
//  clear in  asynchronous active-high reset
//  en    in  high while in a memory-access state; low clears the count
//  done  out last cycle of the access (count == LIMIT)
module mem_wait_counter #(
   parameter int unsigned LIMIT = 0
) (
   input  logic clock,
   input  logic clear,
   input  logic en,
   output logic done
);
   logic [3:0] cnt_q, cnt_d;
   assign done = cnt_q == LIMIT[3:0];
   // Wraps to 0 on the exit cycle so the next access starts fresh
   always_comb cnt_d = (!en || done) ? 4'd0 : cnt_q + 4'd1;
   always_ff @(posedge clock or posedge clear)
      if (clear) cnt_q <= 4'd0;
      else       cnt_q <= cnt_d;
endmodule

// File: rtl/ldst_control_unit.sv
// ldst_control_unit: Moore control sequencer driving DataPath strobes for fetch and ld/ldi/st
//  clock, clear            rising-edge clock, asynchronous active-high reset
//  ir[31:0], stop          instruction (opcode ir[31:27]), halt request at instruction boundary
//  PCout..Zlowout, we      datapath strobes and memory write enable
//  alu_op[4:0]             ALU_ADD in T4 of ld/ldi/st, else 0
//  run, illegal            sequencing flag; sticky unknown-opcode flag
//  Optional feature: define CTRL_ILLEGAL_TRAP_EN to halt on unknown opcodes and set illegal.
module ldst_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        stop,
   output logic        PCout,
   output logic        IncPC,
   output logic        PCin,
   output logic        MARin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Gra,
   output logic        Grb,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Yin,
   output logic        Cout,
   output logic        ZlowIn,
   output logic        Zlowout,
   output logic        we,
   output logic [4:0]  alu_op,
   output logic        run,
   output logic        illegal
);
   state_t     state_q, state_d, done_tgt;
   cls_t       cls_q, cls_d;
   logic       mem_st, mem_done;
   logic [4:0] opc;
   logic       unused_ir;
   assign opc       = ir[31:27];
   assign unused_ir = ^ir[26:0];
   // Only states that actually touch memory stall
   assign mem_st = state_q == S_T1 || (state_q == S_T6 && cls_q == CLS_LD) ||
                   (state_q == S_T7 && cls_q == CLS_ST);
   mem_wait_counter #(.LIMIT(MEM_WAIT)) u_wait (
      .clock(clock), .clear(clear), .en(mem_st), .done(mem_done)
   );
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
   assign illegal = illegal_q;
   always_ff @(posedge clock or posedge clear)
      if (clear) illegal_q <= 1'b0;
      else       illegal_q <= illegal_d;
`else
   assign illegal = 1'b0;
`endif
   always_comb begin
      state_d  = state_q;
      cls_d    = cls_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      done_tgt = stop ? S_HALT : S_T0;
      {PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin} = '0;
      {Gra, Grb, Rin, Rout, BAout, Yin, Cout, ZlowIn, Zlowout, we} = '0;
      alu_op   = 5'b0;
      run      = state_q != S_RESET && state_q != S_HALT;
      case (state_q)
         S_RESET: state_d = S_T0;
         S_T0: begin
            {PCout, MARin, IncPC, ZlowIn} = '1;
            state_d = S_T1;
         end
         S_T1: begin
            {Zlowout, PCin, Read, MDRin} = '1;
            state_d = mem_done ? S_T2 : S_T1;
         end
         S_T2: begin
            {MDRout, IRin} = '1;
            cls_d   = opc == OP_LD ? CLS_LD : opc == OP_LDI ? CLS_LDI : opc == OP_ST ? CLS_ST : CLS_NONE;
            state_d = opc == OP_HALT ? S_HALT : cls_d == CLS_NONE ? done_tgt : S_T3;
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (cls_d == CLS_NONE && opc != OP_NOP && opc != OP_HALT) begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end
`endif
         end
         S_T3: begin
            {Grb, BAout, Yin, Rout} = '1;
            state_d = S_T4;
         end
         S_T4: begin
            {Cout, ZlowIn} = '1;
            alu_op  = ALU_ADD;
            state_d = S_T5;
         end
         S_T5: begin
            Zlowout = 1'b1;
            {Gra, Rin} = {2{cls_q == CLS_LDI}};
            MARin   = cls_q != CLS_LDI;
            state_d = cls_q == CLS_LDI ? done_tgt : S_T6;
         end
         S_T6: begin
            MDRin   = 1'b1;
            Read    = cls_q == CLS_LD;
            {Gra, Rout} = {2{cls_q == CLS_ST}};
            state_d = (cls_q == CLS_ST || mem_done) ? S_T7 : S_T6;
         end
         S_T7: begin
            {MDRout, Gra, Rin} = {3{cls_q == CLS_LD}};
            we      = cls_q == CLS_ST;
            state_d = (cls_q == CLS_LD || mem_done) ? done_tgt : S_T7;
         end
         default: state_d = state_q;
      endcase
   end
   always_ff @(posedge clock or posedge clear)
      if (clear) begin
         state_q <= S_RESET;
         cls_q   <= CLS_NONE;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
      end
endmodule

// File: tb/tb_ldst_control_unit.sv
// tb_ldst_control_unit: scoreboard bench running MEM_WAIT=0 and MEM_WAIT=2 sequencers side by side
module tb_ldst_control_unit;
   typedef logic [24:0] vec_t;
   typedef struct {
      vec_t exp;
      logic stp;
   } ent_t;
   localparam vec_t ILL     = 25'd1;
   localparam vec_t RUN     = 25'd1 << 1;
   localparam vec_t ADD     = 25'd3 << 2;
   localparam vec_t WE      = 25'd1 << 7;
   localparam vec_t ZLOWOUT = 25'd1 << 8;
   localparam vec_t ZLOWIN  = 25'd1 << 9;
   localparam vec_t COUT    = 25'd1 << 10;
   localparam vec_t YIN     = 25'd1 << 11;
   localparam vec_t BAOUT   = 25'd1 << 12;
   localparam vec_t ROUT    = 25'd1 << 13;
   localparam vec_t RIN     = 25'd1 << 14;
   localparam vec_t GRB     = 25'd1 << 15;
   localparam vec_t GRA     = 25'd1 << 16;
   localparam vec_t IRIN    = 25'd1 << 17;
   localparam vec_t MDROUT  = 25'd1 << 18;
   localparam vec_t MDRIN   = 25'd1 << 19;
   localparam vec_t READ    = 25'd1 << 20;
   localparam vec_t MARIN   = 25'd1 << 21;
   localparam vec_t PCIN    = 25'd1 << 22;
   localparam vec_t INCPC   = 25'd1 << 23;
   localparam vec_t PCOUT   = 25'd1 << 24;
   localparam int K_LD = 0, K_LDI = 1, K_ST = 2, K_NOP = 3, K_HALT = 4, K_ILL = 5;
`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        stop0 = 1'b0;
   logic        stop2 = 1'b0;
   logic [31:0] ir = 32'h0;
   wire  [24:0] vec0, vec2;
   int          n_cmp = 0, n_bad = 0;
   ent_t        q0[$], q2[$];
   always #5 clock = ~clock;
   ldst_control_unit #(.MEM_WAIT(0)) dut0 (
      .clock(clock), .clear(clear), .ir(ir), .stop(stop0),
      .PCout(vec0[24]), .IncPC(vec0[23]), .PCin(vec0[22]), .MARin(vec0[21]), .Read(vec0[20]),
      .MDRin(vec0[19]), .MDRout(vec0[18]), .IRin(vec0[17]), .Gra(vec0[16]), .Grb(vec0[15]),
      .Rin(vec0[14]), .Rout(vec0[13]), .BAout(vec0[12]), .Yin(vec0[11]), .Cout(vec0[10]),
      .ZlowIn(vec0[9]), .Zlowout(vec0[8]), .we(vec0[7]), .alu_op(vec0[6:2]), .run(vec0[1]),
      .illegal(vec0[0])
   );
   ldst_control_unit #(.MEM_WAIT(2)) dut2 (
      .clock(clock), .clear(clear), .ir(ir), .stop(stop2),
      .PCout(vec2[24]), .IncPC(vec2[23]), .PCin(vec2[22]), .MARin(vec2[21]), .Read(vec2[20]),
      .MDRin(vec2[19]), .MDRout(vec2[18]), .IRin(vec2[17]), .Gra(vec2[16]), .Grb(vec2[15]),
      .Rin(vec2[14]), .Rout(vec2[13]), .BAout(vec2[12]), .Yin(vec2[11]), .Cout(vec2[10]),
      .ZlowIn(vec2[9]), .Zlowout(vec2[8]), .we(vec2[7]), .alu_op(vec2[6:2]), .run(vec2[1]),
      .illegal(vec2[0])
   );
   task automatic chk(input string tag, input vec_t got, input vec_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic put(input int d, input vec_t e, input logic s);
      ent_t x;
      x.exp = e;
      x.stp = s;
      if (d == 0) q0.push_back(x);
      else        q2.push_back(x);
   endtask
   task automatic halts(input int d, input int n, input vec_t v);
      for (int i = 0; i < n; i++) put(d, v, 1'b0);
   endtask
   // Expected per-cycle strobes of one instruction; stop rides on the final state
   task automatic inst(input int d, input int k, input logic s_end, input logic s_t4);
      int w;
      w = (d == 0) ? 0 : 2;
      put(d, RUN | PCOUT | MARIN | INCPC | ZLOWIN, 1'b0);
      for (int i = 0; i <= w; i++) put(d, RUN | ZLOWOUT | PCIN | READ | MDRIN, 1'b0);
      if (k >= K_NOP) begin
         put(d, RUN | MDROUT | IRIN, s_end);
         return;
      end
      put(d, RUN | MDROUT | IRIN, 1'b0);
      put(d, RUN | GRB | BAOUT | YIN | ROUT, 1'b0);
      put(d, RUN | COUT | ZLOWIN | ADD, s_t4);
      if (k == K_LDI) begin
         put(d, RUN | ZLOWOUT | GRA | RIN, s_end);
         return;
      end
      put(d, RUN | ZLOWOUT | MARIN, 1'b0);
      if (k == K_LD) begin
         for (int i = 0; i <= w; i++) put(d, RUN | READ | MDRIN, 1'b0);
         put(d, RUN | MDROUT | GRA | RIN, s_end);
      end else begin
         put(d, RUN | GRA | ROUT | MDRIN, 1'b0);
         for (int i = 0; i < w; i++) put(d, RUN | WE, 1'b0);
         put(d, RUN | WE, s_end);
      end
   endtask
   task automatic begin_phase(input logic [31:0] v);
      ir = v;
      put(0, '0, 1'b0);
      put(2, '0, 1'b0);
   endtask
   task automatic go();
      ent_t e;
      int   n;
      n = 0;
      @(negedge clock);
      clear = 1'b1;
      stop0 = 1'b0;
      stop2 = 1'b0;
      @(negedge clock);
      clear = 1'b0;
      forever begin
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk($sformatf("w0 ir=%h step%0d", ir, n), vec0, e.exp);
            stop0 = e.stp;
         end else stop0 = 1'b0;
         if (q2.size() != 0) begin
            e = q2.pop_front();
            chk($sformatf("w2 ir=%h step%0d", ir, n), vec2, e.exp);
            stop2 = e.stp;
         end else stop2 = 1'b0;
         n++;
         if (q0.size() == 0 && q2.size() == 0) break;
         if (n > 400) begin
            chk("timeout", vec_t'(q0.size() + q2.size()), '0);
            q0.delete();
            q2.delete();
            break;
         end
         @(negedge clock);
      end
   endtask
   initial begin
      #1;
      chk("reset w0", vec0, '0);
      chk("reset w2", vec2, '0);
      begin_phase(32'h1180_0000);
      for (int d = 0; d <= 2; d += 2) begin
         inst(d, K_ST, 1'b0, 1'b0);
         inst(d, K_ST, 1'b1, 1'b0);
         halts(d, 3, '0);
      end
      go();
      begin_phase(32'h0080_1234);
      for (int d = 0; d <= 2; d += 2) begin
         inst(d, K_LD, 1'b0, 1'b1);
         inst(d, K_LD, 1'b1, 1'b0);
         halts(d, 3, '0);
      end
      go();
      begin_phase(32'h0880_0010);
      for (int d = 0; d <= 2; d += 2) begin
         inst(d, K_LDI, 1'b0, 1'b0);
         inst(d, K_LDI, 1'b0, 1'b0);
      end
      go();
      begin_phase(32'hD800_0000);
      for (int d = 0; d <= 2; d += 2) begin
         inst(d, K_HALT, 1'b0, 1'b0);
         halts(d, 20, '0);
      end
      go();
      begin_phase(32'hD000_0000);
      for (int d = 0; d <= 2; d += 2) begin
         inst(d, K_NOP, 1'b0, 1'b0);
         inst(d, K_NOP, 1'b1, 1'b0);
         halts(d, 2, '0);
      end
      go();
      begin_phase(32'hB800_0000);
      for (int d = 0; d <= 2; d += 2) begin
         if (TRAP) begin
            inst(d, K_ILL, 1'b0, 1'b0);
            halts(d, 3, ILL);
         end else begin
            inst(d, K_ILL, 1'b0, 1'b0);
            inst(d, K_ILL, 1'b1, 1'b0);
            halts(d, 2, '0);
         end
      end
      go();
      begin_phase(32'h0080_0000);
      put(0, RUN | PCOUT | MARIN | INCPC | ZLOWIN, 1'b0);
      put(0, RUN | ZLOWOUT | PCIN | READ | MDRIN, 1'b0);
      put(0, RUN | MDROUT | IRIN, 1'b0);
      put(0, RUN | GRB | BAOUT | YIN | ROUT, 1'b0);
      put(0, RUN | COUT | ZLOWIN | ADD, 1'b0);
      put(0, RUN | ZLOWOUT | MARIN, 1'b0);
      put(2, RUN | PCOUT | MARIN | INCPC | ZLOWIN, 1'b0);
      for (int i = 0; i < 3; i++) put(2, RUN | ZLOWOUT | PCIN | READ | MDRIN, 1'b0);
      put(2, RUN | MDROUT | IRIN, 1'b0);
      put(2, RUN | GRB | BAOUT | YIN | ROUT, 1'b0);
      go();
      #1 clear = 1'b1;
      #1;
      chk("async clear w0", vec0, '0);
      chk("async clear w2", vec2, '0);
      @(negedge clock);
      clear = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
